// File: rtl/astar_pkg.sv
// Shared A* definitions: grid geometry, neighbour direction codes and cell addressing.
package astar_pkg;

    localparam int unsigned GRID_W      = 40;
    localparam int unsigned GRID_H      = 40;
    localparam int unsigned COORD_W     = 8;
    localparam int unsigned CELL_ADDR_W = 11;
    localparam int unsigned MAX_STEPS   = GRID_W * GRID_H;

    localparam logic [COORD_W-1:0] NO_CELL = 8'hFF;

    // Neighbour order shared with the search core's neighbour generator
    typedef enum logic [2:0] {
        DIR_NW = 3'd0,
        DIR_N  = 3'd1,
        DIR_NE = 3'd2,
        DIR_E  = 3'd3,
        DIR_SE = 3'd4,
        DIR_S  = 3'd5,
        DIR_SW = 3'd6,
        DIR_W  = 3'd7
    } dir_e;

    function automatic logic [CELL_ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                         input logic [COORD_W-1:0] y);
        return CELL_ADDR_W'(CELL_ADDR_W'(y) * CELL_ADDR_W'(GRID_W) + CELL_ADDR_W'(x));
    endfunction

endpackage

// File: rtl/astar_dir_step.sv
// Applies one predecessor direction to a cell and flags steps that leave the grid.
module astar_dir_step
    import astar_pkg::*;
(
    input  logic [COORD_W-1:0] cur_x,
    input  logic [COORD_W-1:0] cur_y,
    input  logic [2:0]         dir,
    output logic [COORD_W-1:0] next_x,
    output logic [COORD_W-1:0] next_y,
    output logic               out_of_bounds
);

    localparam int unsigned SW = COORD_W + 1;
    localparam logic signed [SW-1:0] M1   = '1;
    localparam logic signed [SW-1:0] P1   = SW'(1);
    localparam logic signed [SW-1:0] GW_S = SW'(GRID_W);
    localparam logic signed [SW-1:0] GH_S = SW'(GRID_H);

    logic signed [SW-1:0] dx, dy, nx, ny;

    // Signed one-bit-wider arithmetic so a step below zero is visible as negative
    always_comb begin
        dx = '0;
        dy = '0;
        case (dir_e'(dir))
            DIR_NW: begin dx = M1; dy = M1; end
            DIR_N:  begin dy = M1;          end
            DIR_NE: begin dx = P1; dy = M1; end
            DIR_E:  begin dx = P1;          end
            DIR_SE: begin dx = P1; dy = P1; end
            DIR_S:  begin dy = P1;          end
            DIR_SW: begin dx = M1; dy = P1; end
            DIR_W:  begin dx = M1;          end
            default: ;
        endcase
        nx = $signed({1'b0, cur_x}) + dx;
        ny = $signed({1'b0, cur_y}) + dy;
        next_x = nx[COORD_W-1:0];
        next_y = ny[COORD_W-1:0];
        out_of_bounds = nx[SW-1] || ny[SW-1] || (nx >= GW_S) || (ny >= GH_S);
    end

endmodule

// File: rtl/astar_path_tracer.sv
// Walks the predecessor map from goal back to start, streaming each cell as a path beat.
module astar_path_tracer
    import astar_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [COORD_W-1:0]     start_x,
    input  logic [COORD_W-1:0]     start_y,
    input  logic [COORD_W-1:0]     goal_x,
    input  logic [COORD_W-1:0]     goal_y,
    output logic                   pred_rd,
    output logic [CELL_ADDR_W-1:0] pred_addr,
    input  logic [3:0]             pred_data,
    output logic                   path_valid,
    input  logic                   path_ready,
    output logic [COORD_W-1:0]     path_x,
    output logic [COORD_W-1:0]     path_y,
    output logic                   path_last,
    output logic                   done,
    output logic                   error,
    output logic [CELL_ADDR_W-1:0] path_len
);

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_READ, S_WAIT} state_e;

    localparam logic [COORD_W-1:0]     GRID_W_C    = COORD_W'(GRID_W);
    localparam logic [COORD_W-1:0]     GRID_H_C    = COORD_W'(GRID_H);
    localparam logic [CELL_ADDR_W-1:0] MAX_STEPS_C = CELL_ADDR_W'(MAX_STEPS);

    state_e                  state, state_n;
    logic [COORD_W-1:0]      start_x_q, start_y_q, start_x_n, start_y_n;
    logic [COORD_W-1:0]      cur_x_n, cur_y_n, step_x, step_y;
    logic [CELL_ADDR_W-1:0]  len_n, addr_n;
    logic                    step_oob, cmd_bad, done_n, error_n, last_n;

    astar_dir_step u_step (
        .cur_x         (path_x),
        .cur_y         (path_y),
        .dir           (pred_data[2:0]),
        .next_x        (step_x),
        .next_y        (step_y),
        .out_of_bounds (step_oob)
    );

    assign cmd_bad = (start_x >= GRID_W_C) || (goal_x >= GRID_W_C) ||
                     (start_y >= GRID_H_C) || (goal_y >= GRID_H_C);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // path_x/path_y double as the current-cell register
    always_comb begin
        state_n   = state;
        start_x_n = start_x_q;
        start_y_n = start_y_q;
        cur_x_n   = path_x;
        cur_y_n   = path_y;
        len_n     = path_len;
        addr_n    = pred_addr;
        done_n    = 1'b0;
        error_n   = 1'b0;
        case (state)
            S_IDLE: if (cmd_valid) begin
                if (cmd_bad) begin
                    error_n = 1'b1;
                end else begin
                    start_x_n = start_x;
                    start_y_n = start_y;
                    cur_x_n   = goal_x;
                    cur_y_n   = goal_y;
                    len_n     = '0;
                    state_n   = S_EMIT;
                end
            end
            S_EMIT: if (path_ready) begin
                len_n = path_len + CELL_ADDR_W'(1);
                if (path_x == start_x_q && path_y == start_y_q) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (len_n == MAX_STEPS_C) begin
                    error_n = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    addr_n  = cell_addr(path_x, path_y);
                    state_n = S_READ;
                end
            end
            S_READ: state_n = S_WAIT;
            S_WAIT: begin
                if (!pred_data[3] || step_oob) begin
                    error_n = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    cur_x_n = step_x;
                    cur_y_n = step_y;
                    state_n = S_EMIT;
                end
            end
            default: state_n = S_IDLE;
        endcase
        last_n = (state_n == S_EMIT) && (cur_x_n == start_x_n) && (cur_y_n == start_y_n);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_ready  <= 1'b1;
            path_valid <= 1'b0;
            path_x     <= NO_CELL;
            path_y     <= NO_CELL;
            path_last  <= 1'b0;
            pred_rd    <= 1'b0;
            pred_addr  <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
            path_len   <= '0;
            start_x_q  <= '0;
            start_y_q  <= '0;
        end else begin
            cmd_ready  <= (state_n == S_IDLE);
            path_valid <= (state_n == S_EMIT);
            path_x     <= cur_x_n;
            path_y     <= cur_y_n;
            path_last  <= last_n;
            pred_rd    <= (state_n == S_READ);
            pred_addr  <= addr_n;
            done       <= done_n;
            error      <= error_n;
            path_len   <= len_n;
            start_x_q  <= start_x_n;
            start_y_q  <= start_y_n;
        end
    end

endmodule

// File: doc/astar_path_tracer.md
# astar_path_tracer

Walks the A* predecessor map backward from goal to start once the search core has closed the goal cell, emitting the path as a valid/ready stream of (x,y) cells for the VGA path overlay and downstream consumers. It sits directly downstream of the A* search FSM and owns its RECONSTRUCT phase. Reads predecessor codes through a 1-cycle-latency read port and reports done, error and path length.

## Interface
- GRID_W, 40, grid width in cells
- GRID_H, 40, grid height in cells
- COORD_W, 8, coordinate width; 8'hFF reserved as "no cell"
- MAX_STEPS, 1600 (GRID_W*GRID_H), loop guard on emitted cells
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- cmd_valid  in  1  trace request
- cmd_ready  out  1  high only in IDLE
- start_x, start_y  in  COORD_W  search origin
- goal_x, goal_y  in  COORD_W  search target, first emitted cell
- pred_rd  out  1  predecessor read strobe
- pred_addr  out  11  cell address = y*GRID_W + x
- pred_data  in  4  [3] valid, [2:0] direction to predecessor; valid the cycle after pred_rd
- path_valid  out  1  path beat valid
- path_ready  in  1  consumer accepts beat
- path_x, path_y  out  COORD_W  path cell
- path_last  out  1  beat is the start cell
- done  out  1  one-cycle pulse, trace complete
- error  out  1  one-cycle pulse, trace aborted
- path_len  out  11  cells emitted by the latest trace

## Operation
- Direction codes match the search core's neighbour order: 0 NW(-1,-1), 1 N(0,-1), 2 NE(+1,-1), 3 E(+1,0), 4 SE(+1,+1), 5 S(0,+1), 6 SW(-1,+1), 7 W(-1,0). Next cell = current + offset.
- States are IDLE, EMIT, READ and WAIT.
- IDLE: cmd_ready=1. On cmd_valid:
  - If any coordinate is ≥ its grid dimension, pulse error next cycle and stay in IDLE.
  - Otherwise latch start, set cur=goal, clear path_len, go to EMIT.
- EMIT: path_valid=1, path_x/y=cur, path_last=(cur==start). On handshake path_len++, then:
  - if last: pulse done, go to IDLE;
  - else if path_len+1 == MAX_STEPS: pulse error, go to IDLE;
  - else go to READ.
- READ: pred_rd=1, pred_addr=cur_y*GRID_W+cur_x, go to WAIT.
- WAIT: sample pred_data.
  - If valid=0, or the next cell has x or y outside 0..GRID-1 (including underflow below 0): pulse error, go to IDLE.
  - Otherwise cur=next, go to EMIT.
- Arithmetic: offsets are applied in COORD_W+1 signed width. pred_addr is computed in 11 bits unsigned.
- path_x, path_y and path_last are held stable while path_valid && !path_ready.
- cmd_valid outside IDLE is ignored.
- path_len holds its value until the next accepted command. It is not cleared by done or error.

## Timing
- Reset values: cmd_ready=1, path_valid=0, path_x=path_y=8'hFF, path_last=0, pred_rd=0, pred_addr=0, done=0, error=0, path_len=0. State returns to IDLE.
- Command accepted at edge 0: first beat (goal) has path_valid high in cycle 1.
- With path_ready held high, each beat takes 3 cycles (EMIT, READ, WAIT). Beat i is valid in cycle 1+3i.
- done or error is high in the cycle after the terminating handshake or WAIT decode.
- A start==goal trace issues no pred_rd.
- Reset mid-trace: all outputs take reset values immediately. An in-flight beat is dropped and a pending pred_data is ignored. A new command is accepted on the first edge after release.

## Structure
- Shared package astar_pkg holds:
  - GRID_W, GRID_H, COORD_W, CELL_ADDR_W=11, NO_CELL=8'hFF;
  - direction enum DIR_NW..DIR_W, shared with the search core's neighbour generator;
  - function cell_addr(x,y).
- Sub-module astar_dir_step: combinational; takes cur_x, cur_y and dir; returns next_x, next_y and out_of_bounds.

## Test plan
- Trivial path: start=goal=(0,0). Required: one beat (0,0) with path_last=1 in cycle 1, done in cycle 2, path_len=1, pred_rd never asserted.
- Full diagonal: pred(k,k)={1,NW} for k=1..39; start (0,0), goal (39,39), path_ready=1. Required: 40 beats (39,39)..(0,0), path_last only on the final beat (cycle 118), done in cycle 119, path_len=40, 39 reads.
- Backpressure: rerun the diagonal case with path_ready high 1 cycle in 3. Required: identical beat sequence, path_x/y stable across stalls, path_len=40.
- Invalid predecessor: goal (5,5) with pred(5,5) valid=0. Required: one beat (5,5), one read at pred_addr=205, error pulse, path_len=1, no done.
- Bounds and loop guard:
  - goal (0,3) with pred dir W: error after the first beat.
  - pred(1,1)=E and pred(2,1)=W, goal (1,1), start (0,0): error when path_len reaches 1600.
  - command with goal_x=40: error, no beats.
- Reset mid-trace: assert reset during beat 10 of the diagonal case. Required: path_valid falls to 0 immediately, cmd_ready=1 after release, and a new trace completes correctly.
